// File: rtl/module_debounce_n.sv
// module_debounce_n: N-channel debouncer with synchroniser, sample
// prescaler, stability flag and per-channel rise/fall pulses.
module module_debounce_n #(
  parameter int WIDTH          = 4,
  parameter int SAMPLE_DIV     = 1000,
  parameter int STABLE_SAMPLES = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int PER_CHANNEL    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] stable_out,
  output logic             enable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int RW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(SAMPLE_DIV - 1);
  localparam logic [RW-1:0] RMAX = RW'(STABLE_SAMPLES);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [CW-1:0]                     r_cnt;
  logic [WIDTH-1:0]                  w_sync;
  logic [WIDTH-1:0]                  w_commit;
  logic                              w_tick;
  logic                              w_en_nxt;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_tick = (r_cnt == CMAX);

  // Synchroniser chain: newest sample enters at index 0
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
  end

  // Prescaler: wraps at SAMPLE_DIV-1 with no idle cycle
  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

  if (PER_CHANNEL == 0) begin : g_vec
    logic [WIDTH-1:0] r_cand;
    logic [RW-1:0]    r_run;
    logic [RW-1:0]    w_run_nxt;

    // Run length of the whole vector, restarted by any differing bit
    always_comb begin
      w_run_nxt = r_run;
      if (w_sync != r_cand)  w_run_nxt = RW'(1);
      else if (r_run != RMAX) w_run_nxt = r_run + RW'(1);
    end

    // Candidate and run length advance only on a sample tick
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cand <= '0;
        r_run  <= '0;
      end else if (w_tick) begin
        r_cand <= w_sync;
        r_run  <= w_run_nxt;
      end
    end

    assign w_commit = {WIDTH{w_run_nxt == RMAX}};
    assign w_en_nxt = (w_run_nxt == RMAX);
  end else begin : g_chan
    logic [WIDTH-1:0] w_ok;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic          r_cand;
      logic [RW-1:0] r_run;
      logic [RW-1:0] w_run_nxt;

      // Run length of this channel alone
      always_comb begin
        w_run_nxt = r_run;
        if (w_sync[i] != r_cand) w_run_nxt = RW'(1);
        else if (r_run != RMAX)  w_run_nxt = r_run + RW'(1);
      end

      // Per-channel candidate and run length, ticked
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cand <= 1'b0;
          r_run  <= '0;
        end else if (w_tick) begin
          r_cand <= w_sync[i];
          r_run  <= w_run_nxt;
        end
      end

      assign w_ok[i] = (w_run_nxt == RMAX);
    end

    assign w_commit = w_ok;
    assign w_en_nxt = &w_ok;
  end

  // Commit, edge pulses and stability flag; pulses last one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_out <= '0;
      rise       <= '0;
      fall       <= '0;
      enable     <= 1'b0;
    end else begin
      rise <= '0;
      fall <= '0;
      if (w_tick) begin
        stable_out <= (w_sync & w_commit) | (stable_out & ~w_commit);
        rise       <= w_sync & ~stable_out & w_commit;
        fall       <= ~w_sync & stable_out & w_commit;
        enable     <= w_en_nxt;
      end
    end
  end

endmodule

// File: tb/tb_module_debounce_n.sv
// tb_module_debounce_n: three debouncer configurations driven by one
// stimulus stream, checked against a sliding-window reference model.
module tb_module_debounce_n;

  localparam int W   = 4;
  localparam int NI  = 3;
  localparam int SYN = 2;

  logic                  clk;
  logic                  rst;
  logic [W-1:0]          raw_in;
  logic [NI-1:0][W-1:0]  so;
  logic [NI-1:0][W-1:0]  rs;
  logic [NI-1:0][W-1:0]  fl;
  logic [NI-1:0]         en;

  module_debounce_n #(
    .WIDTH(W), .SAMPLE_DIV(4), .STABLE_SAMPLES(4),
    .SYNC_STAGES(SYN), .PER_CHANNEL(0)
  ) u_vec (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .stable_out(so[0]), .enable(en[0]),
    .rise(rs[0]), .fall(fl[0])
  );

  module_debounce_n #(
    .WIDTH(W), .SAMPLE_DIV(4), .STABLE_SAMPLES(4),
    .SYNC_STAGES(SYN), .PER_CHANNEL(1)
  ) u_chan (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .stable_out(so[1]), .enable(en[1]),
    .rise(rs[1]), .fall(fl[1])
  );

  module_debounce_n #(
    .WIDTH(W), .SAMPLE_DIV(1), .STABLE_SAMPLES(1),
    .SYNC_STAGES(SYN), .PER_CHANNEL(0)
  ) u_fast (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .stable_out(so[2]), .enable(en[2]),
    .rise(rs[2]), .fall(fl[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int f_div(int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int f_ss(int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic bit f_pc(int k);
    return (k == 1);
  endfunction

  typedef struct {
    int           k;
    int           cyc;
    logic [W-1:0] r;
    logic [W-1:0] f;
  } ev_t;

  ev_t          evq[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] win[NI][4];
  int           wn[NI];
  int           ntk[NI];
  logic [W-1:0] m_so[NI];
  logic         m_en[NI];
  int           cyc;
  int           errors;
  int           checks;

  initial begin
    cyc    = 0;
    errors = 0;
    checks = 0;
  end

  function automatic void chk(string nm, int k, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h",
               nm, k, cyc, act, exp);
    end
  endfunction

  // Commit rule: the last S tick samples agree (per bit or whole vector)
  function automatic void model_tick(int k, logic [W-1:0] smp);
    int           s;
    logic [W-1:0] ok;
    logic [W-1:0] mask;
    logic [W-1:0] r;
    logic [W-1:0] f;
    bit           all;
    bit           e;
    ev_t          ev;
    s = f_ss(k);
    if (wn[k] == s) begin
      for (int j = 1; j < s; j++) win[k][j-1] = win[k][j];
    end else begin
      wn[k]++;
    end
    win[k][wn[k]-1] = smp;
    ok  = '0;
    all = 1'b0;
    if (wn[k] == s) begin
      ok  = '1;
      all = 1'b1;
      for (int j = 0; j < s; j++) begin
        ok = ok & ~(win[k][j] ^ smp);
        if (win[k][j] != smp) all = 1'b0;
      end
    end
    if (f_pc(k)) begin
      mask = ok;
      e    = &ok;
    end else begin
      mask = {W{all}};
      e    = all;
    end
    r = smp & ~m_so[k] & mask;
    f = ~smp & m_so[k] & mask;
    m_so[k] = (smp & mask) | (m_so[k] & ~mask);
    m_en[k] = e;
    if ((r | f) != '0) begin
      ev.k   = k;
      ev.cyc = cyc;
      ev.r   = r;
      ev.f   = f;
      evq.push_back(ev);
    end
  endfunction

  // Reference model, evaluated once per clock edge
  always @(posedge clk) begin
    logic [W-1:0] smp;
    cyc++;
    if (rst) begin
      hist = {};
      for (int i = 0; i < SYN; i++) hist.push_back('0);
      for (int k = 0; k < NI; k++) begin
        wn[k]   = 0;
        ntk[k]  = 0;
        m_so[k] = '0;
        m_en[k] = 1'b0;
      end
    end else begin
      smp = hist.pop_front();
      hist.push_back(raw_in);
      for (int k = 0; k < NI; k++) begin
        if ((ntk[k] % f_div(k)) == f_div(k) - 1) model_tick(k, smp);
        ntk[k]++;
      end
    end
  end

  // Monitor: level outputs every cycle, pulses against the event queue
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      bit hit;
      chk("stable_out", k, int'(so[k]), int'(m_so[k]));
      chk("enable", k, int'(en[k]), int'(m_en[k]));
      if ((rs[k] | fl[k]) != '0) begin
        hit = 1'b0;
        for (int i = 0; i < evq.size(); i++) begin
          if (!hit && evq[i].k == k) begin
            hit = 1'b1;
            chk("pulse_cycle", k, cyc, evq[i].cyc);
            chk("rise", k, int'(rs[k]), int'(evq[i].r));
            chk("fall", k, int'(fl[k]), int'(evq[i].f));
            evq.delete(i);
          end
        end
        if (!hit) chk("spurious_pulse", k, int'({rs[k], fl[k]}), 0);
      end
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].k == k && evq[i].cyc <= cyc) begin
          chk("missed_pulse", k, 0, int'({evq[i].r, evq[i].f}));
          evq.delete(i);
        end
      end
    end
  end

  task automatic hold(int n, logic [W-1:0] v);
    raw_in = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] v;
    rst    = 1'b1;
    raw_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(30, 4'b0000);
    // clean press
    hold(30, 4'b0100);
    // bounce on bit1, then settle
    hold(20, 4'b0000);
    for (int i = 0; i < 14; i++) hold(3, (i % 2) ? 4'b0000 : 4'b0010);
    hold(30, 4'b0010);
    // release
    hold(30, 4'b0100);
    hold(30, 4'b0000);
    // bit0 changes while bit3 chatters
    for (int i = 0; i < 20; i++) hold(2, (i % 2) ? 4'b0001 : 4'b1001);
    hold(30, 4'b0001);
    hold(30, 4'b0000);
    // reset part-way through a run
    hold(8, 4'b1000);
    rst = 1'b1;
    hold(2, 4'b1000);
    rst = 1'b0;
    hold(30, 4'b1000);
    // randomized segments with occasional reset
    for (int i = 0; i < 250; i++) begin
      v = W'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 3) == 0) v = raw_in ^ W'(1 << $urandom_range(0, W - 1));
      rst = ($urandom_range(0, 39) == 0);
      hold(int'($urandom_range(1, 22)), v);
      rst = 1'b0;
    end
    hold(40, 4'b0000);
    chk("pending_events", 0, evq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
